dsha_result_filter: RTL and testbench

Downstream stage of the double-SHA256 finisher. For every finished hash it:
- compares the hash against a programmable 256-bit target;
- queues the nonces of qualifying hashes ("hits") in a small FIFO;
- presents them to the host-side reporting logic over a valid/ready handshake.

It also keeps a running count of hashes checked, used for hashrate reporting.

---
 rtl/dsha_result_filter.sv | 126 ++++++++++++
 tb/tb_dsha_result_filter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsha_result_filter.sv
// Hit filter behind the double-SHA256 finisher: compares each hash with a target and queues winning nonces.
// Optional DSHA_HASHCNT_EN adds a free-running hash_count output.
module dsha_result_filter #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         hash_valid,
    input  logic [255:0] hash_in,
    input  logic [31:0]  nonce_in,
    input  logic [255:0] target_in,
    input  logic         target_load,
    output logic         res_valid,
    output logic [31:0]  res_nonce,
    input  logic         res_ready,
    output logic         overflow
`ifdef DSHA_HASHCNT_EN
    ,
    output logic [31:0]  hash_count
`endif
);

    localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int STAGES = 1;

    generate
        if (FIFO_DEPTH < 2 || FIFO_DEPTH > 64 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("FIFO_DEPTH must be a power of two in 2..64");
        end
    endgenerate

    logic [255:0]     target;
    logic [STAGES:0]  vld_pipe;
    logic [31:0]      s1_nonce;
    logic             s1_hi_lt;
    logic             s1_hi_eq;
    logic             s1_lo_le;

    logic [31:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic             hit;
    logic             push;
    logic             pop;
    logic             full;
    logic             accept;

    always_ff @(posedge clk) begin
        if (reset)
            target <= '1;
        else if (target_load)
            target <= target_in;
    end

    // The 256-bit compare is split into two 128-bit halves so the critical
    // path is one 128-bit comparator per stage rather than a full-width one.
    assign vld_pipe[0] = hash_valid;

    always_ff @(posedge clk) begin
        if (reset)
            vld_pipe[STAGES:1] <= '0;
        else
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    always_ff @(posedge clk) begin
        if (hash_valid) begin
            s1_nonce <= nonce_in;
            s1_hi_lt <= hash_in[255:128] <  target[255:128];
            s1_hi_eq <= hash_in[255:128] == target[255:128];
            s1_lo_le <= hash_in[127:0]   <= target[127:0];
        end
    end

    assign hit    = vld_pipe[1] & (s1_hi_lt | (s1_hi_eq & s1_lo_le));
    assign push   = hit;
    assign pop    = res_valid & res_ready;
    assign full   = (count == (AW+1)'(FIFO_DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign accept = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= s1_nonce;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push && !accept)
                overflow <= 1'b1;
        end
    end

    assign res_valid = (count != '0);
    assign res_nonce = mem[rd_ptr];

`ifdef DSHA_HASHCNT_EN
    logic [31:0] hash_cnt;

    always_ff @(posedge clk) begin
        if (reset)
            hash_cnt <= '0;
        else if (hash_valid)
            hash_cnt <= hash_cnt + 32'd1;
    end

    assign hash_count = hash_cnt;
`endif

endmodule

// File: tb/tb_dsha_result_filter.sv
// Scoreboard bench for dsha_result_filter: stimulus queues expected hit nonces,
// a negedge monitor checks every accepted FIFO head against that queue.
module tb_dsha_result_filter;

    logic         clk;
    logic         reset;
    logic         hash_valid;
    logic [255:0] hash_in;
    logic [31:0]  nonce_in;
    logic [255:0] target_in;
    logic         target_load;
    logic         res_valid;
    logic [31:0]  res_nonce;
    logic         res_ready;
    logic         overflow;
`ifdef DSHA_HASHCNT_EN
    logic [31:0]  hash_count;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] expq [$];

    dsha_result_filter #(.FIFO_DEPTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .hash_valid  (hash_valid),
        .hash_in     (hash_in),
        .nonce_in    (nonce_in),
        .target_in   (target_in),
        .target_load (target_load),
        .res_valid   (res_valid),
        .res_nonce   (res_nonce),
        .res_ready   (res_ready),
        .overflow    (overflow)
`ifdef DSHA_HASHCNT_EN
        ,
        .hash_count  (hash_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head must match the oldest expected nonce.
    always @(negedge clk) begin
        if (!reset && res_valid === 1'b1 && res_ready === 1'b1) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got %0h expected none", res_nonce);
            end else begin
                chk("pop_nonce", {32'h0, res_nonce}, {32'h0, expq.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        res_ready   = 1'b0;
        hash_valid  = 1'b0;
        target_load = 1'b0;
        reset       = 1'b1;
        expq.delete();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input logic [255:0] h, input logic [31:0] n, input bit exp_hit);
        hash_valid = 1'b1;
        hash_in    = h;
        nonce_in   = n;
        if (exp_hit)
            expq.push_back(n);
        tick();
        hash_valid = 1'b0;
    endtask

    task automatic load_target(input logic [255:0] t);
        target_load = 1'b1;
        target_in   = t;
        tick();
        target_load = 1'b0;
    endtask

    task automatic drain(input string name);
        res_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (expq.size() == 0 && res_valid === 1'b0 && i > 2)
                break;
            tick();
        end
        chk({name, "_left"}, 64'(expq.size()), 64'd0);
        chk({name, "_rv"}, {63'h0, res_valid}, 64'd0);
        res_ready = 1'b0;
    endtask

    logic [255:0] tb_t;

    initial begin
        reset = 1'b1; hash_valid = 1'b0; hash_in = '0; nonce_in = '0;
        target_in = '0; target_load = 1'b0; res_ready = 1'b0;
        do_reset();
        chk("rst_res_valid", {63'h0, res_valid}, 64'd0);
        chk("rst_overflow",  {63'h0, overflow},  64'd0);
`ifdef DSHA_HASHCNT_EN
        chk("rst_hash_count", {32'h0, hash_count}, 64'd0);
`endif

        // Reset-default target: everything hits, latency is two edges.
        send(256'hDEADBEEF_00000000_12345678_9ABCDEF0_FFFFFFFF_00000000_CAFEF00D_55AA55AA, 32'd1, 1'b1);
        chk("lat_rv_n1", {63'h0, res_valid}, 64'd0);
        send(256'h1, 32'd2, 1'b1);
        chk("lat_rv_n2", {63'h0, res_valid}, 64'd1);
        send('1, 32'd3, 1'b1);
        tick();
        drain("order");

        // Exact boundary around target = 0x00000000_FFFF...
        tb_t = {32'h0, {224{1'b1}}};
        load_target(tb_t);
        res_ready = 1'b1;
        send(tb_t, 32'd10, 1'b1);
        send({32'h1, 224'h0}, 32'd11, 1'b0);
        send({32'h0, {96{1'b1}}, {127{1'b1}}, 1'b0}, 32'd12, 1'b1);
        send(256'h0, 32'd13, 1'b1);
        send({32'h1, 224'h5}, 32'd14, 1'b0);
        drain("boundary");

        // hi halves equal, low half decides.
        tb_t = {128'h0123_4567_89AB_CDEF_0000_0000_0000_0001, 128'h8000_0000_0000_0000_0000_0000_0000_0000};
        load_target(tb_t);
        res_ready = 1'b1;
        send({tb_t[255:128], 128'h8000_0000_0000_0000_0000_0000_0000_0001}, 32'd15, 1'b0);
        send({tb_t[255:128], 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF}, 32'd16, 1'b1);
        send({tb_t[255:129], 1'b0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF}, 32'd17, 1'b1);
        drain("lo_half");

        // Target switch: hash in the load cycle sees the old target.
        load_target('1);
        res_ready   = 1'b1;
        target_load = 1'b1;
        target_in   = '0;
        send(256'h5, 32'd20, 1'b1);
        target_load = 1'b0;
        send(256'h5, 32'd21, 1'b0);
        send(256'h0, 32'd22, 1'b1);
        drain("switch");

        // Full FIFO with no pop: 9th hit is dropped and overflow sticks.
        load_target('1);
        res_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            send(256'h77, 32'd30 + 32'(i), i < 8);
        tick();
        tick();
        chk("full_overflow", {63'h0, overflow}, 64'd1);
        chk("full_rv", {63'h0, res_valid}, 64'd1);
        chk("full_head", {32'h0, res_nonce}, 64'd30);
        drain("full");
        chk("overflow_sticky", {63'h0, overflow}, 64'd1);

        // Full FIFO with a pop in the 9th push cycle: nothing dropped.
        do_reset();
        chk("rst2_overflow", {63'h0, overflow}, 64'd0);
        for (int i = 0; i < 9; i++)
            send(256'h99, 32'd40 + 32'(i), 1'b1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        chk("pushpop_overflow", {63'h0, overflow}, 64'd0);
        chk("pushpop_head", {32'h0, res_nonce}, 64'd41);
        drain("pushpop");
        chk("pushpop_overflow2", {63'h0, overflow}, 64'd0);

        // Reset mid-stream: 3 queued + 1 in stage 1, all discarded.
        for (int i = 0; i < 4; i++)
            send(256'h3, 32'd50 + 32'(i), 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_rv", {63'h0, res_valid}, 64'd0);
        chk("midrst_overflow", {63'h0, overflow}, 64'd0);
        tick();
        tick();
        tick();
        chk("midrst_rv_late", {63'h0, res_valid}, 64'd0);
        res_ready = 1'b1;
        send(256'h3, 32'd60, 1'b1);
        drain("after_rst");

`ifdef DSHA_HASHCNT_EN
        do_reset();
        send(256'h1, 32'd70, 1'b1);
        send(256'h1, 32'd71, 1'b1);
        send(256'h1, 32'd72, 1'b1);
        chk("hash_count_3", {32'h0, hash_count}, 64'd3);
        drain("cnt_drain");
        @(negedge clk);
        force dut.hash_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.hash_cnt;
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        send(256'h1, 32'd73, 1'b1);
        send(256'h1, 32'd74, 1'b1);
        chk("hash_count_wrap", {32'h0, hash_count}, 64'd1);
        drain("cnt_drain2");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
